// File: rtl/ls_mem_responder.sv
// Memory-side responder for LS tile requests: one request at a time through
// IDLE/ACCESS/RESP, a 2**addr_width-word local memory, and saturating access counters.
module ls_mem_responder #(
  parameter int ctrl_width = 13,
  parameter int data_width = 32,
  parameter int addr_width = 6,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ctrl_width-1:0] req_ctrl,
  input  logic [data_width-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_rdata,
  output logic                  rsp_op,
  output logic [addr_width-1:0] rsp_addr,
  output logic [cnt_width-1:0]  rd_count,
  output logic [cnt_width-1:0]  wr_count
);

  localparam int depth = 1 << addr_width;
  localparam logic [cnt_width-1:0] cnt_max = '1;
  localparam logic [cnt_width-1:0] cnt_one = cnt_width'(1);

  if (ctrl_width != 2 * addr_width + 1) begin : g_bad_ctrl_width
    $error("ls_mem_responder: ctrl_width must equal 2*addr_width+1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic                  accept;
  logic                  access;
  logic                  rsp_fire;

  logic [addr_width-1:0] ea_next;
  logic [addr_width-1:0] ea_reg;
  logic                  op_reg;
  logic [data_width-1:0] wdata_reg;

  logic [data_width-1:0] rsp_rdata_reg;
  logic                  rsp_op_reg;
  logic [addr_width-1:0] rsp_addr_reg;
  logic [cnt_width-1:0]  rd_count_reg;
  logic [cnt_width-1:0]  wr_count_reg;

  logic [data_width-1:0] mem_word [depth];
  logic [data_width-1:0] mem_rd;

  // Carry out of the address add is dropped, giving modulo-depth wrap.
  assign ea_next = req_ctrl[addr_width:1] + req_ctrl[ctrl_width-1 -: addr_width];
  assign mem_rd  = mem_word[ea_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    rsp_fire   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Held low during reset so no request is seen as accepted.
        req_ready = en & reset;
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        access     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ea_reg    <= '0;
      op_reg    <= 1'b0;
      wdata_reg <= '0;
    end else if (accept) begin
      ea_reg    <= ea_next;
      op_reg    <= req_ctrl[0];
      wdata_reg <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata_reg <= '0;
      rsp_op_reg    <= 1'b0;
      rsp_addr_reg  <= '0;
    end else if (access) begin
      rsp_rdata_reg <= op_reg ? wdata_reg : mem_rd;
      rsp_op_reg    <= op_reg;
      rsp_addr_reg  <= ea_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else if (rsp_fire) begin
      if (!rsp_op_reg && rd_count_reg != cnt_max) begin
        rd_count_reg <= rd_count_reg + cnt_one;
      end
      if (rsp_op_reg && wr_count_reg != cnt_max) begin
        wr_count_reg <= wr_count_reg + cnt_one;
      end
    end
  end

  // One resettable register per memory word; written only from ACCESS on a store.
  for (genvar gi = 0; gi < depth; gi++) begin : g_mem
    logic [data_width-1:0] word_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        word_reg <= '0;
      end else if (access && op_reg && ea_reg == addr_width'(gi)) begin
        word_reg <= wdata_reg;
      end
    end

    assign mem_word[gi] = word_reg;
  end

  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_op    = rsp_op_reg;
  assign rsp_addr  = rsp_addr_reg;
  assign rd_count  = rd_count_reg;
  assign wr_count  = wr_count_reg;

endmodule

// File: tb/tb_ls_mem_responder.sv
// Directed bench for ls_mem_responder: latency, data path, wrap, backpressure,
// enable gating, async reset abandon and counter saturation (narrow-counter copy).
module tb_ls_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [12:0] req_ctrl = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_op;
  logic [5:0]  rsp_addr;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  logic        s_en = 1'b0;
  logic        s_req_ready;
  logic        s_rsp_valid;
  logic [31:0] s_rsp_rdata;
  logic        s_rsp_op;
  logic [5:0]  s_rsp_addr;
  logic [2:0]  s_rd_count;
  logic [2:0]  s_wr_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_rd = '0;
  logic [15:0] exp_wr = '0;

  always #5 clk = ~clk;

  ls_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_op    (rsp_op),
    .rsp_addr  (rsp_addr),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  // Narrow-counter copy so saturation is reachable in a few cycles.
  ls_mem_responder #(.cnt_width(3)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .en        (s_en),
    .req_valid (1'b1),
    .req_ready (s_req_ready),
    .req_ctrl  ({6'd1, 6'd2, 1'b0}),
    .req_wdata (32'h0),
    .rsp_valid (s_rsp_valid),
    .rsp_ready (1'b1),
    .rsp_rdata (s_rsp_rdata),
    .rsp_op    (s_rsp_op),
    .rsp_addr  (s_rsp_addr),
    .rd_count  (s_rd_count),
    .wr_count  (s_wr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One full request: accept, check fixed latency, optional backpressure, handshake.
  task automatic xact(input logic [5:0] off, input logic [5:0] adr, input logic op,
                      input logic [31:0] wd, input logic [31:0] exp_d,
                      input logic [5:0] exp_a, input int hold, input logic drop_en);
    int guard;
    @(negedge clk);
    req_ctrl  = {off, adr, op};
    req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (drop_en) en = 1'b0;
    check("access_no_valid", {31'd0, rsp_valid}, 32'd0);
    check("access_no_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_rdata", rsp_rdata, exp_d);
    check("rsp_addr", {26'd0, rsp_addr}, {26'd0, exp_a});
    check("rsp_op", {31'd0, rsp_op}, {31'd0, op});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_d);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
      check("hold_rd_count", {16'd0, rd_count}, {16'd0, exp_rd});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (op) exp_wr = exp_wr + 16'd1;
    else    exp_rd = exp_rd + 16'd1;
    check("done_valid", {31'd0, rsp_valid}, 32'd0);
    check("done_ready", {31'd0, req_ready}, {31'd0, en});
    check("rd_count", {16'd0, rd_count}, {16'd0, exp_rd});
    check("wr_count", {16'd0, wr_count}, {16'd0, exp_wr});
  endtask

  initial begin
    int guard;
    // Reset state with en already high.
    en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_rd_count", {16'd0, rd_count}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_addr", {26'd0, rsp_addr}, 32'd0);
    check("post_rst_op", {31'd0, rsp_op}, 32'd0);
    check("post_rst_wr_count", {16'd0, wr_count}, 32'd0);

    // Fresh memory reads zero at both ends.
    xact(6'd0, 6'd0, 1'b0, 32'h0, 32'h0, 6'd0, 0, 1'b0);
    xact(6'd0, 6'd63, 1'b0, 32'h0, 32'h0, 6'd63, 0, 1'b0);

    // Store then load back.
    xact(6'd0, 6'd5, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 6'd5, 0, 1'b0);
    xact(6'd0, 6'd5, 1'b0, 32'h0, 32'hDEADBEEF, 6'd5, 0, 1'b0);

    // Wrapped effective address: 10 + 60 = 6, and 7 + 63 = 6.
    xact(6'd60, 6'd10, 1'b1, 32'h00001234, 32'h00001234, 6'd6, 0, 1'b0);
    xact(6'd0, 6'd6, 1'b0, 32'h0, 32'h00001234, 6'd6, 0, 1'b0);
    xact(6'd63, 6'd7, 1'b0, 32'h0, 32'h00001234, 6'd6, 0, 1'b0);

    // Backpressure: hold RESP for 5 cycles.
    xact(6'd0, 6'd5, 1'b0, 32'h0, 32'hDEADBEEF, 6'd5, 5, 1'b0);

    // en low blocks acceptance for 10 cycles.
    @(negedge clk);
    en = 1'b0;
    req_ctrl  = {6'd0, 6'd9, 1'b1};
    req_wdata = 32'hBAD0BAD0;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("en0_ready", {31'd0, req_ready}, 32'd0);
      check("en0_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    req_valid = 1'b0;
    en = 1'b1;

    // en dropped during ACCESS: transaction completes, next request blocked.
    xact(6'd1, 6'd1, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 6'd2, 0, 1'b1);
    req_ctrl  = {6'd0, 6'd2, 1'b0};
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("blocked_ready", {31'd0, req_ready}, 32'd0);
      check("blocked_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    req_valid = 1'b0;
    en = 1'b1;
    xact(6'd0, 6'd2, 1'b0, 32'h0, 32'hCAFEF00D, 6'd2, 0, 1'b0);

    // Async reset during ACCESS of a store to address 3.
    @(negedge clk);
    req_ctrl  = {6'd0, 6'd3, 1'b1};
    req_wdata = 32'h55AA55AA;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rst_acc_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_req_ready", {31'd0, req_ready}, 32'd0);
    check("arst_rdata", rsp_rdata, 32'd0);
    check("arst_addr", {26'd0, rsp_addr}, 32'd0);
    check("arst_rd_count", {16'd0, rd_count}, 32'd0);
    check("arst_wr_count", {16'd0, wr_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_rd = '0;
    exp_wr = '0;
    xact(6'd0, 6'd3, 1'b0, 32'h0, 32'h0, 6'd3, 0, 1'b0);
    xact(6'd0, 6'd5, 1'b0, 32'h0, 32'h0, 6'd5, 0, 1'b0);

    // Saturation on the 3-bit counter copy: reaches 7 and stays there.
    @(negedge clk);
    s_en = 1'b1;
    guard = 0;
    while (s_rd_count != 3'd7 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("sat_reach", {29'd0, s_rd_count}, 32'd7);
    repeat (20) @(negedge clk);
    check("sat_hold", {29'd0, s_rd_count}, 32'd7);
    check("sat_wr_count", {29'd0, s_wr_count}, 32'd0);
    check("sat_addr", {26'd0, s_rsp_addr}, 32'd3);
    s_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
